// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, monitor state type and a saturating counter helper.
// The display pipeline generator uses the same defaults so both ends agree on geometry.
package vga_timing_pkg;

  localparam int VGA_CLK_PER_PIX = 4;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ALIGN    = 2'd1,
    ST_LOCKED   = 2'd2
  } mon_state_t;

  // Counters stop at all-ones so a vanished sync cannot wrap back into a plausible value.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sink_monitor_if.sv
// Pin-level VGA link: the display pipeline drives it (master), the monitor observes it (slave).
interface vga_sink_monitor_if;
  logic       Hsync;
  logic       Vsync;
  logic [3:0] RED;
  logic [3:0] GRN;
  logic [3:0] BLU;

  modport master (output Hsync, Vsync, RED, GRN, BLU);
  modport slave  (input  Hsync, Vsync, RED, GRN, BLU);
endinterface

// File: rtl/vga_sync_edge.sv
// Registers one sync line twice and flags the transition into its active level.
// Both flops reset to the active level so a reset taken mid-pulse cannot fake an edge.
module vga_sync_edge #(
  parameter logic ACT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lead
);

  logic s1;
  logic s2;

  // Stage 1 captures the pin, stage 2 holds the previous level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= ACT;
      s2 <= ACT;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign lead = (s1 == ACT) && (s2 != ACT);

endmodule

// File: rtl/vga_sink_monitor.sv
// Receive-side VGA monitor: recovers pixel timing and coordinates from the syncs,
// verifies line/frame geometry, tracks lock and produces a per-frame colour checksum.
module vga_sink_monitor
  import vga_timing_pkg::*;
#(
  parameter int   CLK_PER_PIX = VGA_CLK_PER_PIX,
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACT    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  vga_sink_monitor_if.slave        vga,
  output logic                     pix_valid,
  output logic [9:0]               pix_x,
  output logic [9:0]               pix_y,
  output logic [11:0]              pix_rgb,
  output logic                     locked,
  output logic                     frame_done,
  output logic [15:0]              frame_sum,
  output logic [15:0]              frame_cnt,
  output logic                     geom_err
);

  localparam int PW = $clog2(CLK_PER_PIX);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_PER_PIX - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(CLK_PER_PIX / 2);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_LO   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_HI   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_HI   = 10'(V_SYNC + V_BP + V_ACTIVE);

  logic          h_lead;
  logic          v_lead;
  logic [11:0]   rgb1;
  logic [11:0]   rgb2;
  logic [PW-1:0] phase;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [15:0]   acc;
  mon_state_t    state;
  logic          err;
  logic          sample;
  logic          visible;

  vga_sync_edge #(.ACT(SYNC_ACT)) u_hs_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (vga.Hsync),
    .lead (h_lead)
  );

  vga_sync_edge #(.ACT(SYNC_ACT)) u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (vga.Vsync),
    .lead (v_lead)
  );

  // Colour goes through the same two register stages as the syncs so it lines up with the edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb1 <= '0;
      rgb2 <= '0;
    end else begin
      rgb1 <= {vga.RED, vga.GRN, vga.BLU};
      rgb2 <= rgb1;
    end
  end

  // Pixel phase and horizontal position, restarted by every Hsync leading edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      h_cnt <= '0;
    end else if (h_lead) begin
      phase <= '0;
      h_cnt <= '0;
    end else if (phase == PH_LAST) begin
      phase <= '0;
      h_cnt <= sat_inc(h_cnt);
    end else begin
      phase <= phase + 1'b1;
    end
  end

  // Line count: Vsync restarts it and wins over a coincident Hsync increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_cnt <= '0;
    end else if (v_lead) begin
      v_cnt <= '0;
    end else if (h_lead) begin
      v_cnt <= sat_inc(v_cnt);
    end
  end

  assign err     = (state != ST_UNLOCKED) &&
                   ((h_lead && (h_cnt != H_LAST)) || (v_lead && (v_cnt != V_LAST)));
  assign sample  = (phase == PH_MID);
  assign visible = (h_cnt >= H_LO) && (h_cnt < H_HI) && (v_cnt >= V_LO) && (v_cnt < V_HI);

  // Lock FSM with registered outputs; an error overrides any edge handling in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_UNLOCKED;
      locked     <= 1'b0;
      geom_err   <= 1'b0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      frame_cnt  <= '0;
      acc        <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
    end else begin
      geom_err   <= err;
      frame_done <= 1'b0;
      pix_valid  <= 1'b0;
      if (err) begin
        state  <= ST_UNLOCKED;
        locked <= 1'b0;
        acc    <= '0;
      end else if (v_lead) begin
        acc <= '0;
        case (state)
          ST_UNLOCKED: begin
            state  <= ST_ALIGN;
            locked <= 1'b0;
          end
          ST_ALIGN: begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
          end
          ST_LOCKED: begin
            frame_sum  <= acc;
            frame_cnt  <= frame_cnt + 16'd1;
            frame_done <= 1'b1;
          end
          default: begin
            state  <= ST_UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end else if (sample && visible && (state == ST_LOCKED)) begin
        pix_valid <= 1'b1;
        pix_x     <= h_cnt - H_LO;
        pix_y     <= v_cnt - V_LO;
        pix_rgb   <= rgb2;
        acc       <= acc + {4'h0, rgb2};
      end
    end
  end

endmodule
